// File: rtl/sev_seg_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sev_seg_arb_pkg
// Shared definitions for the seven-segment display arbiter and its
// round-robin selector.
//   DISP_W      width of one display value (four hex digits)
//   MAX_REQ     largest requester count the selector supports
//   arb_state_t arbiter FSM states (GAP is only reachable when the design
//               is built with SEV_SEG_ARB_BLANK_GAP_EN)
//   rr_winner   round-robin search returning winner index plus valid flag
// ----------------------------------------------------------------------------
package sev_seg_arb_pkg;

    localparam int DISP_W  = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_result_t;

    // Search starts just after the previous winner and wraps modulo n, so
    // the previous winner itself is always the last candidate considered.
    function automatic rr_result_t rr_winner(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int unsigned        n
    );
        rr_result_t  res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            cand = (32'(last) + k) % n;
            if (k <= n && !res.valid && req[cand[2:0]]) begin
                res.valid = 1'b1;
                res.idx   = cand[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sev_seg_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector, kept generic so bus arbiters
// can reuse it.
//   NUM_REQ  number of requesters (2..8)
//   req      request vector
//   last     index of the previous winner (search begins at last+1)
//   exclude  requesters that may not win this time
//   idx      winning index (0 when none)
//   valid    a winner exists
// ----------------------------------------------------------------------------
module rr_pick
    import sev_seg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [2:0]         idx,
    output logic               valid
);

    logic [MAX_REQ-1:0] cand;
    rr_result_t         res;

    // Masked requests are zero-padded to the package width so one search
    // function serves every requester count.
    always_comb begin
        cand                = '0;
        cand[NUM_REQ-1:0]   = req & ~exclude;
        res                 = rr_winner(cand, last, NUM_REQ);
        idx                 = res.idx;
        valid               = res.valid;
    end

endmodule

// File: rtl/sev_seg_arbiter.sv
// ----------------------------------------------------------------------------
// sev_seg_arbiter
// Shares one 4-digit seven-segment display among NUM_REQ requesters. Owners
// rotate round-robin, each keeping the display for at least HOLD_CYCLES
// unless it drops its request first. disp_data feeds sev_seg datain.
//
// Optional build macro: SEV_SEG_ARB_BLANK_GAP_EN
//   When defined, every owner change passes through GAP_CYCLES of blank
//   display (no grant) and the next owner is chosen at the end of the gap.
//
// Parameters:
//   NUM_REQ      requesters (2..8)
//   HOLD_CYCLES  minimum cycles an owner keeps the display (>=2)
//   IDLE_VALUE   value shown when nobody owns the display
//   GAP_CYCLES   blank cycles between owners (>=1, gap build only)
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req        per-requester level request
//   req_data   flattened values, requester i at [16*i+15:16*i]
//   gnt        registered one-hot grant
//   owner      index of current owner, 0 when none
//   disp_data  registered value for sev_seg datain
//   busy       high while a requester owns the display
// ----------------------------------------------------------------------------
module sev_seg_arbiter
    import sev_seg_arb_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter int                HOLD_CYCLES = 50000000,
    parameter logic [DISP_W-1:0] IDLE_VALUE  = 16'h0000,
    parameter int                GAP_CYCLES  = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DISP_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [2:0]                owner,
    output logic [DISP_W-1:0]         disp_data,
    output logic                      busy
);

    localparam int               CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t          state;
    logic [CNT_W-1:0]    hold_cnt;
    logic [2:0]          last;

    logic [NUM_REQ-1:0]  exclude;
    logic [2:0]          pick_idx;
    logic                pick_valid;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic                owner_req;
    logic [DISP_W-1:0]   own_data;
    logic [DISP_W-1:0]   win_data;

`ifdef SEV_SEG_ARB_BLANK_GAP_EN
    localparam int               GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0]    gap_cnt;
`else
    // GAP_CYCLES only matters for the blank-gap build.
    logic                unused_gap_cfg;
    assign unused_gap_cfg = (GAP_CYCLES > 0);
`endif

    // While showing, the current owner never competes: it either released
    // or is being rotated away from at hold expiry.
    assign exclude   = (state == SHOW) ? gnt : '0;
    assign owner_req = |(req & gnt);

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .last    (last),
        .exclude (exclude),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    assign pick_onehot = NUM_REQ'(1) << pick_idx;

    // Value muxes for the current owner and for the candidate winner.
    always_comb begin
        own_data = IDLE_VALUE;
        win_data = IDLE_VALUE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == i[2:0]) begin
                own_data = req_data[i*DISP_W +: DISP_W];
            end
            if (pick_idx == i[2:0]) begin
                win_data = req_data[i*DISP_W +: DISP_W];
            end
        end
    end

    // Arbiter FSM. All outputs are registered here so gnt, owner, busy and
    // disp_data always change together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            disp_data <= IDLE_VALUE;
            hold_cnt  <= '0;
            last      <= 3'(NUM_REQ - 1);
`ifdef SEV_SEG_ARB_BLANK_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= SHOW;
                        gnt       <= pick_onehot;
                        owner     <= pick_idx;
                        last      <= pick_idx;
                        busy      <= 1'b1;
                        disp_data <= win_data;
                        hold_cnt  <= '0;
                    end else begin
                        gnt       <= '0;
                        owner     <= '0;
                        busy      <= 1'b0;
                        disp_data <= IDLE_VALUE;
                    end
                end

                SHOW: begin
                    if (owner_req && hold_cnt != HOLD_MAX) begin
                        // Still inside the hold window: nobody can preempt.
                        hold_cnt  <= hold_cnt + 1'b1;
                        disp_data <= own_data;
                    end else if (pick_valid) begin
                        // Owner released, or hold expired with a contender.
`ifdef SEV_SEG_ARB_BLANK_GAP_EN
                        state     <= GAP;
                        gnt       <= '0;
                        owner     <= '0;
                        busy      <= 1'b0;
                        disp_data <= IDLE_VALUE;
                        hold_cnt  <= '0;
                        gap_cnt   <= '0;
`else
                        gnt       <= pick_onehot;
                        owner     <= pick_idx;
                        last      <= pick_idx;
                        disp_data <= win_data;
                        hold_cnt  <= '0;
`endif
                    end else if (owner_req) begin
                        // Hold expired but nobody else wants the display.
                        hold_cnt  <= '0;
                        disp_data <= own_data;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        owner     <= '0;
                        busy      <= 1'b0;
                        disp_data <= IDLE_VALUE;
                        hold_cnt  <= '0;
                    end
                end

`ifdef SEV_SEG_ARB_BLANK_GAP_EN
                GAP: begin
                    // The next owner is chosen from the requests present at
                    // the end of the gap, not those seen when it started.
                    if (gap_cnt == GAP_MAX) begin
                        gap_cnt <= '0;
                        if (pick_valid) begin
                            state     <= SHOW;
                            gnt       <= pick_onehot;
                            owner     <= pick_idx;
                            last      <= pick_idx;
                            busy      <= 1'b1;
                            disp_data <= win_data;
                            hold_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    owner     <= '0;
                    busy      <= 1'b0;
                    disp_data <= IDLE_VALUE;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sev_seg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sev_seg_arbiter
// Self-checking bench for sev_seg_arbiter with NUM_REQ=4, HOLD_CYCLES=4,
// GAP_CYCLES=2, IDLE_VALUE=0. Honours SEV_SEG_ARB_BLANK_GAP_EN so the same
// bench covers both builds.
// ----------------------------------------------------------------------------
module tb_sev_seg_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int GAPC = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic [15:0] disp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    sev_seg_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (HOLD),
        .IDLE_VALUE  (16'h0000),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .owner     (owner),
        .disp_data (disp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  exp_gnt;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t vecs[$];

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [63:0] d);
        rst      = r;
        req      = rq;
        req_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic checkAll(input string tag, input logic [3:0] eg, input logic [15:0] ed);
        checkOutput({tag, "_gnt"},   32'(gnt),       32'(eg));
        checkOutput({tag, "_disp"},  32'(disp_data), 32'(ed));
        checkOutput({tag, "_busy"},  32'(busy),      32'(eg != 4'b0));
        checkOutput({tag, "_owner"}, 32'(owner),     32'(idx_of(eg)));
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [63:0] d,
                                input logic [3:0] eg, input logic [15:0] ed);
        vec_t v;
        v.rst = r; v.req = rq; v.data = d; v.exp_gnt = eg; v.exp_disp = ed;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Owner is an integer (-1 = nobody); "held" counts cycles since grant.
    int          m_owner, m_last, m_held, m_gap;
    logic [15:0] m_disp;

    function automatic int rr_model(input logic [3:0] r, input int lastp, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (lastp + k) % N;
            if (r[c[1:0]] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic logic [15:0] word(input logic [63:0] d, input int i);
        return 16'(d >> (16 * i));
    endfunction

    task automatic modelGrant(input int w, input logic [63:0] d);
        m_owner = w; m_last = w; m_held = 0; m_disp = word(d, w);
    endtask

    task automatic modelIdle();
        m_owner = -1; m_held = 0; m_gap = -1; m_disp = 16'h0000;
    endtask

    task automatic modelChange(input int w, input logic [63:0] d);
`ifdef SEV_SEG_ARB_BLANK_GAP_EN
        m_owner = -1; m_held = 0; m_gap = 0; m_disp = 16'h0000;
        if (w < 0) m_gap = 0;
`else
        modelGrant(w, d);
`endif
    endtask

    task automatic modelStep(input logic r, input logic [3:0] rq, input logic [63:0] d);
        int w;
        if (r) begin
            modelIdle();
            m_last = N - 1;
        end else if (m_gap >= 0) begin
            if (m_gap == GAPC - 1) begin
                m_gap = -1;
                w = rr_model(rq, m_last, -1);
                if (w >= 0) modelGrant(w, d); else modelIdle();
            end else begin
                m_gap++;
            end
        end else if (m_owner < 0) begin
            w = rr_model(rq, m_last, -1);
            if (w >= 0) modelGrant(w, d);
        end else if (rq[m_owner[1:0]] && m_held < HOLD - 1) begin
            m_held++;
            m_disp = word(d, m_owner);
        end else begin
            w = rr_model(rq, m_last, m_owner);
            if (w >= 0) modelChange(w, d);
            else if (rq[m_owner[1:0]]) begin m_held = 0; m_disp = word(d, m_owner); end
            else modelIdle();
        end
    endtask

    initial begin
        logic [63:0] d0101;
        logic [3:0]  eg;
        logic [3:0]  rq;
        logic [63:0] dd;
        logic        rr;

        rst = 1'b1; req = 4'b0; req_data = 64'h0;
        d0101 = {16'h0000, 16'hABCD, 16'h0000, 16'h1234};

        // Table: reset, idle stretch, then the alternating 0101 pattern.
        vecs.push_back(mk(1'b1, 4'b0000, 64'h0, 4'b0000, 16'h0000));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1'b0, 4'b0000, 64'hFFFF_EEEE_DDDD_CCCC, 4'b0000, 16'h0000));
        vecs.push_back(mk(1'b1, 4'b0000, 64'h0, 4'b0000, 16'h0000));
`ifdef SEV_SEG_ARB_BLANK_GAP_EN
        for (int k = 1; k <= 13; k++) begin
            if (k <= 4 || k == 13)          eg = 4'b0001;
            else if (k >= 7 && k <= 10)     eg = 4'b0100;
            else                            eg = 4'b0000;
            vecs.push_back(mk(1'b0, 4'b0101, d0101, eg,
                              eg == 4'b0001 ? 16'h1234 : (eg == 4'b0100 ? 16'hABCD : 16'h0000)));
        end
`else
        for (int k = 1; k <= 9; k++) begin
            eg = (k <= 4 || k == 9) ? 4'b0001 : 4'b0100;
            vecs.push_back(mk(1'b0, 4'b0101, d0101, eg, eg == 4'b0001 ? 16'h1234 : 16'hABCD));
        end
`endif
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_disp);
        end

        // Sole requester with live data change: no glitch at hold expiry.
        applyStimulus(1'b1, 4'b0000, 64'h0);
        for (int k = 1; k <= 10; k++) begin
            dd = {16'h0, 16'h0, (k >= 7) ? 16'h0002 : 16'h0001, 16'h0};
            applyStimulus(1'b0, 4'b0010, dd);
            checkAll($sformatf("solo%0d", k), 4'b0010, (k >= 7) ? 16'h0002 : 16'h0001);
        end

        // Early release by owner 0 while requester 3 waits.
        applyStimulus(1'b1, 4'b0000, 64'h0);
        dd = {16'h3333, 16'h0, 16'h0, 16'h1111};
        applyStimulus(1'b0, 4'b1001, dd);
        checkAll("rel_grant", 4'b0001, 16'h1111);
        applyStimulus(1'b0, 4'b1001, dd);
        checkAll("rel_cnt1", 4'b0001, 16'h1111);
        applyStimulus(1'b0, 4'b1000, dd);
`ifdef SEV_SEG_ARB_BLANK_GAP_EN
        checkAll("rel_gap0", 4'b0000, 16'h0000);
        applyStimulus(1'b0, 4'b1000, dd);
        checkAll("rel_gap1", 4'b0000, 16'h0000);
        applyStimulus(1'b0, 4'b1000, dd);
`endif
        checkAll("rel_handoff", 4'b1000, 16'h3333);

        // Reset in the middle of SHOW, then all request: requester 0 first.
        applyStimulus(1'b1, 4'b0000, 64'h0);
        dd = {16'h4444, 16'h5555, 16'h6666, 16'h7777};
        applyStimulus(1'b0, 4'b0100, dd);
        checkAll("mid_show", 4'b0100, 16'h5555);
        applyStimulus(1'b1, 4'b0100, dd);
        checkAll("mid_rst", 4'b0000, 16'h0000);
        applyStimulus(1'b0, 4'b1111, dd);
        checkAll("post_rst", 4'b0001, 16'h7777);

        // Randomised traffic against the reference model.
        applyStimulus(1'b1, 4'b0000, 64'h0);
        modelStep(1'b1, 4'b0000, 64'h0);
        rq = 4'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            dd = {$urandom, $urandom};
            rr = ($urandom_range(0, 99) == 0);
            applyStimulus(rr, rq, dd);
            modelStep(rr, rq, dd);
            checkAll($sformatf("rnd%0d", k),
                     (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner), m_disp);
            checkOutput("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
